// File: rtl/pixel_ram_arbiter.sv
// Round-robin arbiter sharing the byte-wide pixel RAM between the window-fetch
// reader (3-byte reads) and the result writer, with read watchdog and range check.
`timescale 1ns/1ps
module pixel_ram_arbiter #(
   parameter int ADDR_WIDTH = 19,
   parameter int TIMEOUT    = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  rd_req,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic                  rd_gnt,
   output logic                  rd_valid,
   output logic [23:0]           rd_data,
   input  logic                  wr_req,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [7:0]            wr_data,
   output logic                  wr_gnt,
   output logic [1:0]            ram_we,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [7:0]            ram_din,
   input  logic [23:0]           ram_dout,
   input  logic                  ram_ready,
   output logic                  busy,
   input  logic                  err_clr,
   output logic                  timeout_err,
   output logic                  addr_err
);

   localparam int CW = $clog2(TIMEOUT);
   // Highest byte address whose 3-byte pixel still fits in the RAM.
   localparam logic [ADDR_WIDTH-1:0] MAX_RD = {ADDR_WIDTH{1'b1}} - ADDR_WIDTH'(2);

   typedef enum logic [1:0] {IDLE, WRITE, READ, REJECT} state_t;

   state_t                state, state_d;
   logic                  last_rd, last_rd_d;
   logic [CW-1:0]         cnt, cnt_d;
   logic [1:0]            ram_we_d;
   logic [ADDR_WIDTH-1:0] ram_addr_d;
   logic [7:0]            ram_din_d;
   logic                  rd_gnt_d, wr_gnt_d, rd_valid_d, busy_d;
   logic [23:0]           rd_data_d;
   logic                  t_set, a_set, timeout_err_d, addr_err_d;

   always_comb begin
      state_d    = state;
      last_rd_d  = last_rd;
      cnt_d      = cnt;
      ram_we_d   = ram_we;
      ram_addr_d = ram_addr;
      ram_din_d  = ram_din;
      rd_gnt_d   = 1'b0;
      wr_gnt_d   = 1'b0;
      rd_valid_d = 1'b0;
      rd_data_d  = rd_data;
      t_set      = 1'b0;
      a_set      = 1'b0;
      case (state)
         IDLE: begin
            if (rd_req && (!wr_req || !last_rd)) begin
               last_rd_d = 1'b1;
               rd_gnt_d  = 1'b1;
               if (rd_addr > MAX_RD) begin
                  state_d = REJECT;
               end else begin
                  state_d    = READ;
                  ram_we_d   = 2'b01;
                  ram_addr_d = rd_addr;
                  cnt_d      = '0;
               end
            end else if (wr_req) begin
               last_rd_d  = 1'b0;
               wr_gnt_d   = 1'b1;
               state_d    = WRITE;
               ram_we_d   = 2'b10;
               ram_addr_d = wr_addr;
               ram_din_d  = wr_data;
            end
         end
         WRITE: begin
            ram_we_d = 2'b00;
            state_d  = IDLE;
         end
         READ: begin
            if (ram_ready) begin
               rd_data_d  = ram_dout;
               rd_valid_d = 1'b1;
               ram_we_d   = 2'b00;
               state_d    = IDLE;
            end else if (cnt == CW'(TIMEOUT - 1)) begin
               rd_data_d  = '0;
               rd_valid_d = 1'b1;
               ram_we_d   = 2'b00;
               t_set      = 1'b1;
               state_d    = IDLE;
            end else begin
               cnt_d = cnt + CW'(1);
            end
         end
         REJECT: begin
            rd_data_d  = '0;
            rd_valid_d = 1'b1;
            a_set      = 1'b1;
            state_d    = IDLE;
         end
         default: begin
            ram_we_d = 2'b00;
            state_d  = IDLE;
         end
      endcase
      // A fresh error on the clearing edge keeps the flag set.
      timeout_err_d = t_set | (timeout_err & ~err_clr);
      addr_err_d    = a_set | (addr_err & ~err_clr);
      busy_d        = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         last_rd     <= 1'b0;
         cnt         <= '0;
         ram_we      <= 2'b00;
         ram_addr    <= '0;
         ram_din     <= '0;
         rd_gnt      <= 1'b0;
         wr_gnt      <= 1'b0;
         rd_valid    <= 1'b0;
         rd_data     <= '0;
         busy        <= 1'b0;
         timeout_err <= 1'b0;
         addr_err    <= 1'b0;
      end else begin
         state       <= state_d;
         last_rd     <= last_rd_d;
         cnt         <= cnt_d;
         ram_we      <= ram_we_d;
         ram_addr    <= ram_addr_d;
         ram_din     <= ram_din_d;
         rd_gnt      <= rd_gnt_d;
         wr_gnt      <= wr_gnt_d;
         rd_valid    <= rd_valid_d;
         rd_data     <= rd_data_d;
         busy        <= busy_d;
         timeout_err <= timeout_err_d;
         addr_err    <= addr_err_d;
      end
   end

endmodule

// File: tb/tb_pixel_ram_arbiter.sv
// Self-checking bench for pixel_ram_arbiter: directed corner cases plus random
// read/write traffic against a byte-array model of the pixel RAM.
`timescale 1ns/1ps
module tb_pixel_ram_arbiter;

   localparam int AW  = 19;
   localparam int TMO = 16;
   localparam int LAT = 6;

   logic          clk, rst_n;
   logic          rd_req, wr_req, err_clr;
   logic [AW-1:0] rd_addr, wr_addr;
   logic [7:0]    wr_data;
   logic          rd_gnt, rd_valid, wr_gnt, busy, timeout_err, addr_err;
   logic [23:0]   rd_data, ram_dout;
   logic [1:0]    ram_we;
   logic [AW-1:0] ram_addr;
   logic [7:0]    ram_din;
   logic          ram_ready;

   int n_cmp = 0;
   int n_err = 0;

   pixel_ram_arbiter #(.ADDR_WIDTH(AW), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst_n(rst_n),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_valid(rd_valid), .rd_data(rd_data),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
      .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
      .ram_ready(ram_ready), .busy(busy), .err_clr(err_clr),
      .timeout_err(timeout_err), .addr_err(addr_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural pixel RAM: 1 KiB image, ready on the 6th cycle of a read.
   logic [7:0] mem [1024];
   logic [7:0] exp_mem [1024];
   logic       init_done = 1'b0;
   logic       stall = 1'b0;
   int         rcnt = 0;
   logic [9:0] ra0, ra1, ra2;

   assign ra0       = ram_addr[9:0];
   assign ra1       = ra0 + 10'd1;
   assign ra2       = ra0 + 10'd2;
   assign ram_dout  = {mem[ra2], mem[ra1], mem[ra0]};
   assign ram_ready = (ram_we == 2'b01) && (rcnt == LAT - 1) && !stall;

   always @(posedge clk) begin
      if (!init_done) begin
         for (int i = 0; i < 1024; i++) mem[i] <= 8'(i * 37 + 11);
         init_done <= 1'b1;
      end else if (ram_we == 2'b10) begin
         mem[ram_addr[9:0]] <= ram_din;
      end
      rcnt <= (ram_we == 2'b01) ? rcnt + 1 : 0;
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [23:0] exp_word(input logic [AW-1:0] a);
      logic [9:0] b;
      b = a[9:0];
      return {exp_mem[10'(b + 10'd2)], exp_mem[10'(b + 10'd1)], exp_mem[b]};
   endfunction

   // Protocol invariants seen on every cycle out of reset.
   always @(negedge clk) begin
      if (rst_n) begin
         check_val("we_code", 32'(ram_we == 2'b11), 0);
         if (rd_gnt || wr_gnt) begin
            check_val("gnt_busy", busy, 1);
            check_val("gnt_excl", rd_gnt & wr_gnt, 0);
         end
      end
   end

   task automatic do_write(input logic [AW-1:0] a, input logic [7:0] d);
      bit found = 0;
      wr_addr = a; wr_data = d; wr_req = 1'b1;
      for (int k = 0; k < 100 && !found; k++) begin
         @(negedge clk);
         if (wr_gnt) found = 1;
      end
      wr_req = 1'b0;
      check_val("wr_gnt_seen", found, 1);
      if (!found) return;
      check_val("wr_we", ram_we, 2'b10);
      check_val("wr_addr", ram_addr, a);
      check_val("wr_din", ram_din, d);
      @(negedge clk);
      check_val("wr_we_off", ram_we, 2'b00);
      check_val("wr_busy_off", busy, 0);
      exp_mem[a[9:0]] = d;
   endtask

   task automatic do_read(input logic [AW-1:0] a, input logic [23:0] ed, input int el,
                          input int ewe, input int clr_at, input bit poke);
      bit found = 0;
      bit got = 0;
      int k = 0;
      int wecnt, wgs = 0, badw = 0;
      rd_addr = a; rd_req = 1'b1;
      for (int j = 0; j < 100 && !found; j++) begin
         @(negedge clk);
         if (rd_gnt) found = 1;
      end
      rd_req = 1'b0;
      check_val("rd_gnt_seen", found, 1);
      if (!found) return;
      wecnt = (ram_we == 2'b01) ? 1 : 0;
      if (poke) begin
         wr_addr = AW'($urandom_range(0, 1023));
         wr_data = 8'($urandom);
      end
      while (k < 100 && !got) begin
         @(negedge clk);
         k++;
         if (rd_valid) got = 1;
         else if (ram_we == 2'b01) wecnt++;
         if (wr_gnt) wgs++;
         if (ram_we == 2'b10) badw++;
         err_clr = (k == clr_at);
         wr_req  = poke && (k == 1 || k == 2);
      end
      err_clr = 1'b0;
      wr_req  = 1'b0;
      check_val("rd_valid_seen", got, 1);
      check_val("rd_latency", k, el);
      check_val("rd_data", rd_data, ed);
      check_val("rd_we_cycles", wecnt, ewe);
      if (poke) begin
         check_val("withdrawn_gnt", wgs, 0);
         check_val("withdrawn_wr", badw, 0);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      #3ms;
      $display("FAIL global_timeout: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      int order [6];
      int ng;
      logic [AW-1:0] a;
      rst_n = 1'b0; rd_req = 0; wr_req = 0; err_clr = 0;
      rd_addr = '0; wr_addr = '0; wr_data = '0;
      for (int i = 0; i < 1024; i++) exp_mem[i] = 8'(i * 37 + 11);
      repeat (3) @(negedge clk);
      check_val("rst_we", ram_we, 0);
      check_val("rst_busy", busy, 0);
      check_val("rst_gnt", {rd_gnt, wr_gnt, rd_valid}, 0);
      check_val("rst_data", rd_data, 0);
      check_val("rst_err", {timeout_err, addr_err}, 0);
      check_val("rst_addr", ram_addr, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Single write, then a 3-byte read of known bytes.
      do_write(19'h00010, 8'hA5);
      do_write(19'h00020, 8'h11);
      do_write(19'h00021, 8'h22);
      do_write(19'h00022, 8'h33);
      do_read(19'h00020, 24'h332211, LAT, LAT, -1, 0);
      @(negedge clk);
      check_val("rd_we_after", ram_we, 0);
      check_val("addr_hold", ram_addr, 19'h00020);

      // Both requesting continuously from reset: reader first, then alternate.
      rd_addr = 19'h00020; wr_addr = 19'h00300; wr_data = 8'h5A;
      rd_req = 1'b1; wr_req = 1'b1;
      do_reset();
      ng = 0;
      for (int c = 0; c < 200 && ng < 6; c++) begin
         @(negedge clk);
         if (rd_gnt || wr_gnt) begin
            order[ng] = rd_gnt ? 1 : 2;
            ng++;
         end
      end
      rd_req = 1'b0; wr_req = 1'b0;
      exp_mem[10'h300] = 8'h5A;
      check_val("rr_count", ng, 6);
      for (int i = 0; i < ng; i++) check_val("rr_order", order[i], (i % 2 == 0) ? 1 : 2);
      repeat (20) @(negedge clk);
      check_val("rr_idle", busy, 0);

      // Watchdog abort, sticky flag, clear, and clear coinciding with a new timeout.
      stall = 1'b1;
      do_read(19'h00040, 24'h0, TMO, TMO, -1, 0);
      check_val("tmo_set", timeout_err, 1);
      repeat (3) @(negedge clk);
      check_val("tmo_sticky", timeout_err, 1);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      check_val("tmo_clr", timeout_err, 0);
      do_read(19'h00040, 24'h0, TMO, TMO, TMO - 1, 0);
      check_val("tmo_clr_race", timeout_err, 1);
      stall = 1'b0;
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;

      // Range boundary: last legal pixel read, first rejected address.
      do_read(19'h7FFFD, exp_word(19'h7FFFD), LAT, LAT, -1, 0);
      check_val("edge_no_aerr", addr_err, 0);
      do_read(19'h7FFFE, 24'h0, 1, 0, -1, 0);
      check_val("aerr_set", addr_err, 1);
      check_val("aerr_no_tmo", timeout_err, 0);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      check_val("aerr_clr", addr_err, 0);

      // Asynchronous reset in the middle of a read.
      rd_addr = 19'h00050; rd_req = 1'b1;
      ng = 0;
      for (int c = 0; c < 50 && ng == 0; c++) begin
         @(negedge clk);
         if (rd_gnt) ng = 1;
      end
      rd_req = 1'b0;
      check_val("mid_gnt", ng, 1);
      repeat (3) @(negedge clk);
      check_val("mid_reading", ram_we, 2'b01);
      #1 rst_n = 1'b0;
      #1;
      check_val("mid_we", ram_we, 0);
      check_val("mid_busy", busy, 0);
      check_val("mid_pulses", {rd_gnt, wr_gnt, rd_valid}, 0);
      check_val("mid_addr", ram_addr, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check_val("mid_idle", busy, 0);
      do_read(19'h00050, exp_word(19'h00050), LAT, LAT, -1, 0);

      // Random traffic against the reference image.
      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(0, 1) == 0) begin
            do_write(AW'($urandom_range(0, 1023)), 8'($urandom));
         end else if ($urandom_range(0, 4) == 0) begin
            a = 19'h7FFFE + AW'($urandom_range(0, 1));
            do_read(a, 24'h0, 1, 0, -1, 0);
         end else begin
            a = AW'($urandom_range(0, 1021));
            do_read(a, exp_word(a), LAT, LAT, -1, 1'($urandom_range(0, 1)));
         end
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/pixel_ram_arbiter.md
Name: pixel_ram_arbiter

Overview:
- Shares the byte-wide single-port pixel RAM between two requesters.
  - Window-fetch reader: 24-bit pixel reads, 3 consecutive bytes.
  - Result writer: 8-bit byte writes.
- Drives the RAM's 2-bit we code, address and write data; waits on its ready strobe.
- Round-robin arbitration, read timeout watchdog, out-of-range read rejection.
- Sits between the convolution engine and the pixel RAM.

Parameters:
- ADDR_WIDTH, 19, RAM byte-address width.
- TIMEOUT, 16, max cycles in READ without ram_ready before abort (must be at least 8).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rd_req  in  1  read request; hold until rd_gnt.
- rd_addr  in  ADDR_WIDTH  pixel byte address; stable while rd_req is high.
- rd_gnt  out  1  one-cycle pulse: read accepted.
- rd_valid  out  1  one-cycle pulse: rd_data valid.
- rd_data  out  24  {byte+2, byte+1, byte+0}.
- wr_req  in  1  write request; hold until wr_gnt.
- wr_addr  in  ADDR_WIDTH  byte address.
- wr_data  in  8  byte to write.
- wr_gnt  out  1  one-cycle pulse: write accepted; write issued the same cycle.
- ram_we  out  2  00 idle, 01 read, 10 write.
- ram_addr  out  ADDR_WIDTH  RAM address.
- ram_din  out  8  RAM write data.
- ram_dout  in  24  RAM read data.
- ram_ready  in  1  RAM read-complete strobe.
- busy  out  1  high whenever state is not IDLE.
- err_clr  in  1  clears sticky error flags.
- timeout_err  out  1  sticky: read aborted by watchdog.
- addr_err  out  1  sticky: read rejected, rd_addr above 2**ADDR_WIDTH-3.

Behaviour:
- Reset values: all outputs registered and cleared to 0; ram_we=00; state=IDLE; last-granted=writer, so the reader wins the first tie.
- States: IDLE, WRITE, READ, REJECT.
- IDLE, arbitration: winner = the only requester, or the one not last granted when both request. Winner's address/data are latched.
- IDLE -> WRITE:
  - At the accept edge: ram_we<=10, ram_addr<=wr_addr, ram_din<=wr_data, wr_gnt<=1.
  - WRITE lasts 1 cycle; next edge: ram_we<=00, back to IDLE.
- IDLE -> READ (rd_addr in range):
  - At the accept edge: ram_we<=01, ram_addr<=rd_addr, rd_gnt<=1, watchdog counter<=0.
- IDLE -> REJECT (rd_addr > 2**ADDR_WIDTH-3):
  - No RAM access; rd_gnt<=1.
  - Next edge: rd_valid<=1, rd_data<=0, addr_err<=1, back to IDLE.
- READ:
  - ram_we held at 01; counter increments each cycle.
  - At the edge where ram_ready is sampled 1: rd_data<=ram_dout, rd_valid<=1, ram_we<=00, back to IDLE.
  - Dropping we on that edge leaves the RAM sequencer in its idle state.
  - Nominal RAM: ram_we=01 is visible for 6 cycles; rd_valid is asserted 6 cycles after the rd_gnt cycle.
- Watchdog: if the counter reaches TIMEOUT-1 without ram_ready: ram_we<=00, rd_valid<=1, rd_data<=0, timeout_err<=1, back to IDLE.
- A grant pulse is never asserted in the same cycle as busy=0. Back-to-back accepts are at least 2 cycles apart.
- ram_addr and ram_din hold their last values when idle.
- Sticky errors:
  - err_clr clears them on the next edge.
  - A new error on the same edge as err_clr wins; the flag stays 1.
- Requester drops req before its grant: the request is withdrawn; no access.
- Reset mid-operation: ram_we goes to 00 asynchronously and all pulses clear. The RAM sequencer may be left mid-sequence, so the first read after such a reset is not guaranteed; the caller reissues it.
- Widths: rd_data is exactly 24 bits; the watchdog counter is $clog2(TIMEOUT) bits.

Test Plan:
- Single write, wr_addr=0x00010, wr_data=0xA5 -> wr_gnt pulse; ram_we=10 for exactly 1 cycle with ram_addr=0x00010, ram_din=0xA5; busy high for 1 cycle.
- Single read, rd_addr=0x00020, RAM bytes 0x11,0x22,0x33 -> rd_gnt; ram_we=01 for 6 cycles; rd_valid 6 cycles after rd_gnt with rd_data=0x332211; ram_we=00 afterwards.
- rd_req and wr_req both asserted continuously from reset -> grants alternate read, write, read, write; no overlapping RAM accesses.
- ram_ready forced to 0 during a read, TIMEOUT=16 -> ram_we=01 for 16 cycles, then 00; rd_valid with rd_data=0; timeout_err=1; stays 1 until err_clr.
- rd_addr=0x7FFFE with ADDR_WIDTH=19 -> rd_gnt, then rd_valid with rd_data=0 and addr_err=1; ram_we stays 00.
- rst_n pulled low during READ cycle 3 -> ram_we=00 immediately, all outputs 0; arbiter idle after release; err_clr asserted on the same edge as a new timeout -> timeout_err remains 1.
